// File: rtl/aes_pkg.sv
// Shared AES datapath types: bytes, 4-byte state rows and the row index.
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0] row_t;
    typedef logic [1:0] row_idx_t;

    localparam int AES_NB = 4;

endpackage

// File: rtl/enc_shifter_row_rotator.sv
// Combinational byte rotator for one state row: a 4:1 byte mux per output byte.
// Rotates left by i_k (ShiftRows); `ENC_SHIFTER_INV_EN rotates right (InvShiftRows).
module row_rotator
    import aes_pkg::*;
(
    input  row_t     i_row,
    input  row_idx_t i_k,
    output row_t     o_row
);

    always_comb begin
        o_row = '0;
        for (int i = 0; i < AES_NB; i++) begin
            row_idx_t w_sel;
`ifdef ENC_SHIFTER_INV_EN
            w_sel = row_idx_t'(i) - i_k;
`else
            w_sel = row_idx_t'(i) + i_k;
`endif
            // 2-bit index arithmetic gives the mod-4 wrap for free
            o_row[i] = i_row[w_sel];
        end
    end

endmodule

// File: rtl/enc_shifter.sv
// ShiftRows stage, one 4-byte row per clock, rotation set by a free-running row counter.
// Define ENC_SHIFTER_INV_EN to build the InvShiftRows (right rotation) variant.
module enc_shifter
    import aes_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_en,
    input  logic [N-1:0][7:0]   inp,
    output logic [N-1:0][7:0]   outp,
    output logic                done
);

    row_idx_t r_row;
    row_t     r_outp;
    logic     r_done;
    row_idx_t w_k;
    row_t     w_rot;

    // wr_en restarts the sequence: the current row is treated as row 0
    assign w_k = wr_en ? row_idx_t'(0) : r_row;

    row_rotator u_rot (
        .i_row (row_t'(inp)),
        .i_k   (w_k),
        .o_row (w_rot)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_row  <= '0;
            r_outp <= '0;
            r_done <= 1'b0;
        end else begin
            r_outp <= w_rot;
            if (wr_en) begin
                r_row  <= row_idx_t'(1);
                r_done <= 1'b0;
            end else begin
                r_row  <= r_row + row_idx_t'(1);
                r_done <= (r_row == row_idx_t'(AES_NB - 1));
            end
        end
    end

    assign outp = r_outp;
    assign done = r_done;

endmodule

// File: tb/tb_enc_shifter.sv
// Scoreboard bench for enc_shifter: the driver queues hand-computed rows, the monitor checks them.
module tb_enc_shifter;

    logic             clk;
    logic             resetn;
    logic             wr_en;
    logic [3:0][7:0]  inp;
    logic [3:0][7:0]  outp;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] out;
        logic        dn;
        int          tag;
    } exp_t;

    exp_t q[$];

    // Packed views are {byte3,byte2,byte1,byte0}; byte0 is column 0.
    localparam logic [31:0] SEQ   = 32'h03020100;
    localparam logic [31:0] SEQ2  = 32'h01000302;
    localparam logic [31:0] MIX   = 32'h44332211;
    localparam logic [31:0] MIX2  = 32'h22114433;
    localparam logic [31:0] A_IN  = 32'hA3A2A1A0;
    localparam logic [31:0] A2    = 32'hA1A0A3A2;
`ifdef ENC_SHIFTER_INV_EN
    localparam logic [31:0] SEQ1  = 32'h02010003;
    localparam logic [31:0] SEQ3  = 32'h00030201;
    localparam logic [31:0] A1    = 32'hA2A1A0A3;
`else
    localparam logic [31:0] SEQ1  = 32'h00030201;
    localparam logic [31:0] SEQ3  = 32'h02010003;
    localparam logic [31:0] A1    = 32'hA0A3A2A1;
`endif

    enc_shifter #(.N(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en),
        .inp    (inp),
        .outp   (outp),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h, expected %h", name, tag, act, req);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input logic [31:0] din, input logic we,
                         input logic [31:0] eout, input logic edone, input int tag);
        exp_t e;
        inp   = din;
        wr_en = we;
        e.out = eout;
        e.dn  = edone;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("outp", e.tag, outp, e.out);
            check("done", e.tag, {31'b0, done}, {31'b0, e.dn});
        end
    end

    initial begin
        resetn = 1'b0;
        wr_en  = 1'b0;
        inp    = SEQ;
        #2;
        check("reset_outp", 0, outp, 32'h0);
        check("reset_done", 0, {31'b0, done}, 32'h0);

        @(negedge clk);
        resetn = 1'b1;

        drive(SEQ, 1'b0, SEQ,  1'b0, 1);
        drive(SEQ, 1'b0, SEQ1, 1'b0, 2);
        drive(SEQ, 1'b0, SEQ2, 1'b0, 3);
        drive(SEQ, 1'b0, SEQ3, 1'b1, 4);
        drive(SEQ, 1'b0, SEQ,  1'b0, 5);
        drive(SEQ, 1'b0, SEQ1, 1'b0, 6);
        drive(MIX, 1'b0, MIX2, 1'b0, 7);
        // counter now at row 3: wr_en must still force row 0 and keep done low
        drive(A_IN, 1'b1, A_IN, 1'b0, 8);
        drive(A_IN, 1'b0, A1,   1'b0, 9);
        drive(A_IN, 1'b0, A2,   1'b0, 10);

        resetn = 1'b0;
        #1;
        check("midrst_outp", 11, outp, 32'h0);
        check("midrst_done", 11, {31'b0, done}, 32'h0);
        #2;
        resetn = 1'b1;
        @(negedge clk);
        // a posedge passed while nothing was queued; reissue row 0 from the fresh start
        resetn = 1'b0;
        #1;
        resetn = 1'b1;

        drive(SEQ, 1'b0, SEQ,  1'b0, 12);
        drive(SEQ, 1'b0, SEQ1, 1'b0, 13);
        drive(SEQ, 1'b0, SEQ2, 1'b0, 14);
        drive(SEQ, 1'b0, SEQ3, 1'b1, 15);
        drive(SEQ, 1'b0, SEQ,  1'b0, 16);

        repeat (2) @(negedge clk);
        check("queue_empty", 17, q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
